// File: rtl/reflex_scan_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reflex_scan_sched_if : scan scheduler bus (mux, ADC handshake, publish). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface reflex_scan_sched_if #(
  parameter int NUM_CH = 4
) ();
  logic              scan_en;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] mux_sel;
  logic              adc_start;
  logic              adc_done;
  logic [15:0]       adc_mem;
  logic [15:0]       adc_piezo;
  logic [15:0]       memristor_ref;
  logic [15:0]       piezo_ref;
  logic [NUM_CH-1:0] ch_sign_o;
  logic              control_rdy;
  logic              ctrl_busy;
  logic              scan_done;
  logic              err_timeout;

  // Scheduler side
  modport master (
    input  scan_en, ch_mask, adc_done, adc_mem, adc_piezo, ctrl_busy,
    output mux_sel, adc_start, memristor_ref, piezo_ref, ch_sign_o,
           control_rdy, scan_done, err_timeout
  );

  // Front-end / controller side
  modport slave (
    output scan_en, ch_mask, adc_done, adc_mem, adc_piezo, ctrl_busy,
    input  mux_sel, adc_start, memristor_ref, piezo_ref, ch_sign_o,
           control_rdy, scan_done, err_timeout
  );
endinterface
`default_nettype wire

// File: rtl/reflex_scan_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reflex_scan_sched : round-robin tactile channel scanner with ADC         |
// | handshake, reflex hold-off and sticky timeout. Option: REFLEX_PRIO_CH_EN |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module reflex_scan_sched #(
  parameter int NUM_CH      = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 255,
  parameter int PRIO_CH     = 1
) (
  input  logic                clk,
  input  logic                rst,
  reflex_scan_sched_if.master bus
);

  localparam int c_ch_w    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_cnt_max = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_settle_last  = c_cnt_w'(SETTLE_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_sat      = c_cnt_w'(c_cnt_max);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_SETTLE  = 3'd2,
    S_CONVERT = 3'd3,
    S_PUBLISH = 3'd4,
    S_HOLD    = 3'd5,
    S_NEXT    = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [c_ch_w-1:0]   r_ptr;
  logic [c_ch_w-1:0]   r_cur;
  logic [NUM_CH-1:0]   r_mask_rr;
  logic                r_is_prio;
  logic [c_cnt_w-1:0]  r_cnt;

  logic [NUM_CH-1:0]   w_rr_mask;
  logic                w_prio_slot;
  logic                w_prio_pick;
  logic                w_rr_found;
  logic [c_ch_w-1:0]   w_cand;
  logic [c_ch_w-1:0]   w_rr_idx;
  logic [c_ch_w-1:0]   w_sel_idx;
  logic                w_sel_ok;
  logic [NUM_CH-1:0]   w_sel_hot;
  logic                w_no_higher;

`ifdef REFLEX_PRIO_CH_EN
  logic                r_prio_due;
`endif

  // The priority channel is served only in its interleaved slot, so it is
  // removed from the round-robin candidates unless it is the only one left.
  always_comb begin
    w_rr_mask   = bus.ch_mask;
    w_prio_slot = 1'b0;
    w_prio_pick = 1'b0;
`ifdef REFLEX_PRIO_CH_EN
    w_rr_mask[PRIO_CH] = 1'b0;
    w_prio_slot = bus.ch_mask[PRIO_CH] & r_prio_due;
    w_prio_pick = bus.ch_mask[PRIO_CH] & (r_prio_due | (w_rr_mask == '0));
`endif
  end

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = r_ptr;
    w_cand     = r_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cand = c_ch_w'((int'(r_ptr) + i) % NUM_CH);
      if (!w_rr_found && w_rr_mask[w_cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_idx = w_prio_pick ? c_ch_w'(PRIO_CH) : w_rr_idx;
    w_sel_ok  = w_prio_pick | w_rr_found;
    w_sel_hot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sel_hot[i] = (w_sel_idx == c_ch_w'(i));
    end
  end

  // End of pass: no round-robin channel above the one just served.
  always_comb begin
    w_no_higher = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((i > int'(r_cur)) && r_mask_rr[i]) begin
        w_no_higher = 1'b0;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (bus.scan_en && (bus.ch_mask != '0)) w_next_state = S_SELECT;
      S_SELECT:  w_next_state = w_sel_ok ? S_SETTLE : S_IDLE;
      S_SETTLE:  if (r_cnt >= c_settle_last) w_next_state = S_CONVERT;
      S_CONVERT: begin
        if (bus.adc_done)                  w_next_state = S_PUBLISH;
        else if (r_cnt >= c_timeout_last)  w_next_state = S_NEXT;
      end
      S_PUBLISH: w_next_state = S_HOLD;
      S_HOLD:    if (!bus.ctrl_busy) w_next_state = S_NEXT;
      S_NEXT:    w_next_state = (bus.scan_en && (bus.ch_mask != '0)) ? S_SELECT : S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr             <= '0;
      r_cur             <= '0;
      r_mask_rr         <= '0;
      r_is_prio         <= 1'b0;
      r_cnt             <= '0;
      bus.mux_sel       <= '0;
      bus.adc_start     <= 1'b0;
      bus.memristor_ref <= '0;
      bus.piezo_ref     <= '0;
      bus.ch_sign_o     <= '0;
      bus.control_rdy   <= 1'b0;
      bus.scan_done     <= 1'b0;
      bus.err_timeout   <= 1'b0;
    end else begin
      bus.adc_start   <= 1'b0;
      bus.control_rdy <= 1'b0;
      bus.scan_done   <= (w_next_state == S_NEXT) && (r_state != S_NEXT) &&
                         w_no_higher && !r_is_prio;
      case (r_state)
        S_SELECT: begin
          r_cnt <= '0;
          if (w_sel_ok) begin
            bus.mux_sel <= w_sel_hot;
            r_cur       <= w_sel_idx;
            r_mask_rr   <= w_rr_mask;
            r_is_prio   <= w_prio_slot;
          end else begin
            bus.mux_sel <= '0;
          end
        end
        S_SETTLE: begin
          if (r_cnt >= c_settle_last) begin
            r_cnt         <= '0;
            bus.adc_start <= 1'b1;
          end else if (r_cnt != c_cnt_sat) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        S_CONVERT: begin
          // A done arriving on the expiry cycle still wins over the timeout.
          if (bus.adc_done) begin
            bus.memristor_ref <= bus.adc_mem;
            bus.piezo_ref     <= bus.adc_piezo;
            bus.ch_sign_o     <= bus.mux_sel;
            bus.control_rdy   <= 1'b1;
          end else if (r_cnt >= c_timeout_last) begin
            bus.err_timeout <= 1'b1;
          end else if (r_cnt != c_cnt_sat) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        S_NEXT: begin
          if (!r_is_prio) begin
            r_ptr <= (r_cur == c_ch_w'(NUM_CH - 1)) ? '0 : r_cur + c_ch_w'(1);
          end
          if (w_next_state == S_IDLE) bus.mux_sel <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef REFLEX_PRIO_CH_EN
  // A priority slot is owed after every channel that was not itself priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_prio_due <= 1'b0;
    else if (r_state == S_NEXT) r_prio_due <= !r_is_prio && (r_cur != c_ch_w'(PRIO_CH));
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reflex_scan_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reflex_scan_sched : directed self-checking bench for reflex_scan_sched|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_reflex_scan_sched;

  localparam int NUM_CH      = 4;
  localparam int SETTLE_CYC  = 16;
  localparam int TIMEOUT_CYC = 255;
  localparam int PRIO_CH     = 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   sd_cnt = 0;
  int   rdy_cnt = 0;

  int          adc_delay;
  bit          adc_mute;
  int          done_cyc = 0;
  logic [15:0] last_mem = '0;
  logic [15:0] last_piezo = '0;

  reflex_scan_sched_if #(.NUM_CH(NUM_CH)) bus ();

  reflex_scan_sched #(
    .NUM_CH(NUM_CH), .SETTLE_CYC(SETTLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .PRIO_CH(PRIO_CH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.scan_done === 1'b1)   sd_cnt  <= sd_cnt + 1;
    if (bus.control_rdy === 1'b1) rdy_cnt <= rdy_cnt + 1;
  end

  // ADC front end: answers each start after adc_delay cycles unless muted.
  initial begin : adc_model
    bit pend;
    int cd;
    int seq;
    pend = 0; cd = 0; seq = 0;
    bus.adc_done = 1'b0; bus.adc_mem = '0; bus.adc_piezo = '0;
    forever begin
      @(posedge clk); #1;
      bus.adc_done = 1'b0;
      if (pend) begin
        cd--;
        if (cd == 0) begin
          seq++;
          bus.adc_done  = 1'b1;
          bus.adc_mem   = 16'h1000 + 16'(seq);
          bus.adc_piezo = 16'hC000 - 16'(seq * 7);
          last_mem      = bus.adc_mem;
          last_piezo    = bus.adc_piezo;
          done_cyc      = cyc;
          pend          = 0;
        end
      end
      if (bus.adc_start === 1'b1 && !adc_mute) begin
        pend = 1;
        cd   = adc_delay;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    tick();
    while (bus.control_rdy !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, 32'(bus.control_rdy), 32'd1);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    tick();
    while (bus.adc_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 32'(bus.adc_start), 32'd1);
  endtask

  task automatic expect_pub(input string tag, input logic [3:0] exp_tag);
    wait_rdy(tag);
    check({tag, "_tag"}, 32'(bus.ch_sign_o), 32'(exp_tag));
    check({tag, "_mem"}, 32'(bus.memristor_ref), 32'(last_mem));
    check({tag, "_pz"},  32'(bus.piezo_ref), 32'(last_piezo));
    check({tag, "_lat"}, 32'(cyc - done_cyc), 32'd1);
  endtask

  logic [3:0] basic_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] prio_seq  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b0010, 4'b1000, 4'b0010};

  initial begin : main
    int n;
    int bad;
    int starts;
    int rdy0;
    rst = 1'b1;
    bus.scan_en = 1'b0; bus.ch_mask = 4'b1111; bus.ctrl_busy = 1'b0;
    adc_delay = 5; adc_mute = 1'b0;
    repeat (3) tick();
    check("rst_ctl", 32'({bus.mux_sel, bus.adc_start, bus.control_rdy,
                          bus.scan_done, bus.err_timeout}), 32'd0);
    check("rst_data", {bus.memristor_ref, bus.piezo_ref}, 32'd0);
    check("rst_tag", 32'(bus.ch_sign_o), 32'd0);
    rst = 1'b0;
    tick();

`ifdef REFLEX_PRIO_CH_EN
    bus.scan_en = 1'b1;
    for (int i = 0; i < 6; i++) expect_pub($sformatf("prio%0d", i), prio_seq[i]);
`else
    // Plain round-robin, full mask
    bus.scan_en = 1'b1;
    for (int i = 0; i < 5; i++) expect_pub($sformatf("rr%0d", i), basic_seq[i]);
    check("rr_scan_done", 32'(sd_cnt), 32'd1);

    // Masked scan, then a mask change during conversion
    bus.ch_mask = 4'b1010;
    expect_pub("msk0", 4'b0010);
    expect_pub("msk1", 4'b1000);
    expect_pub("msk2", 4'b0010);
    wait_start("msk_sw");
    bus.ch_mask = 4'b0100;
    expect_pub("msk3", 4'b1000);
    expect_pub("msk4", 4'b0100);
    expect_pub("msk5", 4'b0100);

    // Reflex hold-off for 300 cycles
    bus.ctrl_busy = 1'b1;
    bad = 0; starts = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.adc_start !== 1'b0) starts++;
      if (bus.mux_sel !== 4'b0100) bad++;
    end
    check("hold_start", 32'(starts), 32'd0);
    check("hold_mux", 32'(bad), 32'd0);
    bus.ctrl_busy = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.adc_start !== 1'b1 && n < 100);
    // NEXT, SELECT, then SETTLE_CYC settle cycles before the start pulse
    check("hold_release", 32'(n), 32'(SETTLE_CYC + 3));
    expect_pub("hold_pub", 4'b0100);

    // ADC timeout on channel 2
    bus.ch_mask = 4'b1111;
    expect_pub("to0", 4'b1000);
    expect_pub("to1", 4'b0001);
    expect_pub("to2", 4'b0010);
    adc_mute = 1'b1;
    wait_start("to");
    check("to_err_pre", 32'(bus.err_timeout), 32'd0);
    rdy0 = rdy_cnt;
    n = 0;
    while (bus.err_timeout !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("to_lat", 32'(n), 32'(TIMEOUT_CYC));
    check("to_no_rdy", 32'(rdy_cnt - rdy0), 32'd0);
    adc_mute = 1'b0;
    expect_pub("to3", 4'b1000);
    check("to_sticky", 32'(bus.err_timeout), 32'd1);

    // Stop during SETTLE: channel 0 still completes, then idle
    repeat (6) tick();
    bus.scan_en = 1'b0;
    check("stop_settle_mux", 32'(bus.mux_sel), 32'b0001);
    expect_pub("stop", 4'b0001);
    repeat (4) tick();
    check("stop_idle_mux", 32'(bus.mux_sel), 32'd0);
    rdy0 = rdy_cnt; starts = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.adc_start !== 1'b0) starts++;
    end
    check("stop_no_start", 32'(starts), 32'd0);
    check("stop_no_rdy", 32'(rdy_cnt - rdy0), 32'd0);

    // Reset during CONVERT, then a late adc_done
    adc_delay = 20;
    bus.scan_en = 1'b1;
    wait_start("rc");
    bus.scan_en = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #2;
    check("rc_mux", 32'(bus.mux_sel), 32'd0);
    check("rc_err", 32'(bus.err_timeout), 32'd0);
    check("rc_data", {bus.memristor_ref, bus.piezo_ref}, 32'd0);
    check("rc_tag", 32'(bus.ch_sign_o), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    rdy0 = rdy_cnt;
    repeat (30) tick();
    check("rc_late_rdy", 32'(rdy_cnt - rdy0), 32'd0);
    check("rc_late_mem", 32'(bus.memristor_ref), 32'd0);
    check("rc_late_mux", 32'(bus.mux_sel), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
